// File: rtl/merge_collect.sv
// Serial-to-parallel word collector with a flush path, popcount,
// a single-entry output holding register and a sticky drop flag.
module merge_collect #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic [CW-1:0]    word_len,
    output logic [CW-1:0]    ones_cnt,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    len_q, len_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] asm_n;
    logic [CW-1:0]    cnt_n;
    logic             load;
    logic [WIDTH-1:0] load_w;
    logic [CW-1:0]    load_l;
    logic             accept;
    logic             hold_free;

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] w);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(w[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        len_d     = len_q;
        ones_d    = ones_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        asm_n     = asm_q;
        cnt_n     = cnt_q;
        load      = 1'b0;
        load_w    = '0;
        load_l    = '0;
        accept    = valid_q && word_ready;
        hold_free = !valid_q || word_ready;

        unique case (state_q)
            S_STALL: begin
                if (bit_valid) begin
                    ovf_d = 1'b1;
                end
                if (accept) begin
                    load    = 1'b1;
                    load_w  = asm_q;
                    load_l  = cnt_q;
                    asm_d   = '0;
                    cnt_d   = '0;
                    state_d = S_EMPTY;
                end
            end
            default: begin
                // asm bits above cnt are always zero, so OR-in is safe
                if (bit_valid) begin
                    asm_n = asm_q | (WIDTH'(bit_in) << cnt_q);
                    cnt_n = cnt_q + CW'(1);
                end
                if (cnt_n == CW'(WIDTH) || (flush && cnt_n != '0)) begin
                    if (hold_free) begin
                        load    = 1'b1;
                        load_w  = asm_n;
                        load_l  = cnt_n;
                        asm_d   = '0;
                        cnt_d   = '0;
                        state_d = S_EMPTY;
                    end else begin
                        asm_d   = asm_n;
                        cnt_d   = cnt_n;
                        state_d = S_STALL;
                    end
                end else begin
                    asm_d   = asm_n;
                    cnt_d   = cnt_n;
                    state_d = (cnt_n == '0) ? S_EMPTY : S_FILL;
                end
            end
        endcase

        if (load) begin
            valid_d = 1'b1;
            word_d  = load_w;
            len_d   = load_l;
            ones_d  = popcnt(load_w);
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            asm_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            len_q   <= len_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_out   = word_q;
    assign word_len   = len_q;
    assign ones_cnt   = ones_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_merge_collect.sv
// Randomised and directed bench for merge_collect against a
// queue-based reference model of the collector.
module tb_merge_collect;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  word_out;
    logic [CW-1:0] word_len;
    logic [CW-1:0] ones_cnt;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          overflow;

    int nvec = 0;
    int nerr = 0;

    merge_collect #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .flush     (flush),
        .word_out  (word_out),
        .word_len  (word_len),
        .ones_cnt  (ones_cnt),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // reference model: pending bits, stalled flag, held word
    bit            mq[$];
    bit            m_stall;
    logic          h_v;
    logic [W-1:0]  h_w;
    logic [CW-1:0] h_l;
    logic [CW-1:0] h_o;
    logic          m_ovf;

    task automatic model_clear();
        mq.delete();
        m_stall = 0;
        h_v = 0; h_w = '0; h_l = '0; h_o = '0;
        m_ovf = 0;
    endtask

    task automatic model_load();
        int ones;
        h_w = '0;
        ones = 0;
        foreach (mq[i]) begin
            h_w[i] = mq[i];
            ones += int'(mq[i]);
        end
        h_l = CW'(mq.size());
        h_o = CW'(ones);
        h_v = 1;
        mq.delete();
        m_stall = 0;
    endtask

    task automatic model_step(input bit bv, input bit bi, input bit fl,
                              input bit rdy);
        bit acc;
        acc = h_v && rdy;
        if (m_stall) begin
            if (bv) m_ovf = 1;
            if (acc) model_load();
        end else begin
            if (bv) mq.push_back(bi);
            if (mq.size() == W || (fl && mq.size() > 0)) begin
                if (!h_v || rdy) model_load();
                else m_stall = 1;
            end else if (acc) begin
                h_v = 0;
            end
        end
    endtask

    task automatic step(input bit bv, input bit bi, input bit fl,
                        input bit rdy);
        bit_valid  = bv;
        bit_in     = bi;
        flush      = fl;
        word_ready = rdy;
        @(posedge clk);
        model_step(bv, bi, fl, rdy);
        #1;
    endtask

    task automatic do_reset();
        bit_valid = 0; flush = 0; word_ready = 0; bit_in = 0;
        rst_n = 0;
        model_clear();
        #1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({word_valid, word_out, word_len, ones_cnt, overflow} !== '0) begin
            nerr++;
            $display("FAIL reset: got v=%b w=%h l=%0d o=%0d ovf=%b want all 0",
                     word_valid, word_out, word_len, ones_cnt, overflow);
        end
    endtask

    task automatic test_full_word();
        logic [W-1:0] pat;
        pat = 8'h8D;
        do_reset();
        for (int i = 0; i < W; i++) begin
            step(1, pat[i], 0, 1);
            nvec++;
            if (word_valid !== (i == W - 1)) begin
                nerr++;
                $display("FAIL full_valid bit%0d: got %b want %b",
                         i, word_valid, (i == W - 1));
            end
        end
        nvec++;
        if ({word_out, word_len, ones_cnt} !== {8'h8D, 4'd8, 4'd4}) begin
            nerr++;
            $display("FAIL full_word: got %h/%0d/%0d want 8d/8/4",
                     word_out, word_len, ones_cnt);
        end
        step(0, 0, 0, 1);
        nvec++;
        if (word_valid !== 1'b0) begin
            nerr++;
            $display("FAIL full_one_cycle: got v=%b want 0", word_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        nvec++;
        if ({word_valid, word_out, word_len, ones_cnt} !==
            {1'b1, 8'h1F, 4'd5, 4'd5}) begin
            nerr++;
            $display("FAIL flush_word: got v=%b %h/%0d/%0d want 1 1f/5/5",
                     word_valid, word_out, word_len, ones_cnt);
        end
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        nvec++;
        if (word_valid !== 1'b0) begin
            nerr++;
            $display("FAIL flush_empty: got v=%b want 0", word_valid);
        end
    endtask

    task automatic test_flush_with_bit();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
        step(1, 0, 1, 1);
        nvec++;
        if ({word_valid, word_out, word_len, ones_cnt} !==
            {1'b1, 8'h07, 4'd4, 4'd3}) begin
            nerr++;
            $display("FAIL flush_bit: got v=%b %h/%0d/%0d want 1 07/4/3",
                     word_valid, word_out, word_len, ones_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        w1 = W'($urandom);
        w2 = W'($urandom);
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1, (i < W) ? w1[i] : w2[i-W], 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            nvec++;
            if ({word_valid, word_out, word_len} !== {1'b1, w1, 4'd8}) begin
                nerr++;
                $display("FAIL stall_hold%0d: got v=%b %h/%0d want 1 %h/8",
                         i, word_valid, word_out, word_len, w1);
            end
        end
        nvec++;
        if (overflow !== 1'b1) begin
            nerr++;
            $display("FAIL stall_ovf: got %b want 1", overflow);
        end
        step(0, 0, 0, 1);
        nvec++;
        if ({word_valid, word_out, word_len} !== {1'b1, w2, 4'd8}) begin
            nerr++;
            $display("FAIL b2b_second: got v=%b %h/%0d want 1 %h/8",
                     word_valid, word_out, word_len, w2);
        end
        step(0, 0, 1, 1);
        nvec++;
        if (word_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_drain: got v=%b want 0 (lost bits gone)",
                     word_valid);
        end
        nvec++;
        if (overflow !== m_ovf) begin
            nerr++;
            $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        do_reset();
        for (int i = 0; i < W; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        #2;
        rst_n = 0;
        model_clear();
        #1;
        nvec++;
        if ({word_valid, word_out, word_len, ones_cnt, overflow} !== '0) begin
            nerr++;
            $display("FAIL reset_mid: got v=%b w=%h l=%0d o=%0d ovf=%b want 0",
                     word_valid, word_out, word_len, ones_cnt, overflow);
        end
        @(negedge clk);
        rst_n = 1;
        w = W'($urandom);
        for (int i = 0; i < W; i++) step(1, w[i], 0, 1);
        nvec++;
        if ({word_valid, word_out, word_len, ones_cnt} !==
            {1'b1, w, 4'd8, CW'($countones(w))}) begin
            nerr++;
            $display("FAIL reset_fresh: got v=%b %h/%0d/%0d want 1 %h/8/%0d",
                     word_valid, word_out, word_len, ones_cnt, w,
                     $countones(w));
        end
    endtask

    task automatic test_random();
        bit bv, bi, fl, rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bv  = ($urandom_range(0, 9) < 7);
            bi  = 1'($urandom);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < ((c / 150) % 2 == 0 ? 5 : 2));
            step(bv, bi, fl, rdy);
            nvec++;
            if (word_valid !== h_v || overflow !== m_ovf) begin
                nerr++;
                $display("FAIL rand_ctl c%0d: got v=%b ovf=%b want v=%b ovf=%b",
                         c, word_valid, overflow, h_v, m_ovf);
            end
            if (h_v) begin
                nvec++;
                if ({word_out, word_len, ones_cnt} !== {h_w, h_l, h_o}) begin
                    nerr++;
                    $display("FAIL rand_word c%0d: got %h/%0d/%0d want %h/%0d/%0d",
                             c, word_out, word_len, ones_cnt, h_w, h_l, h_o);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_word();
        test_flush();
        test_flush_with_bit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/merge_collect.md
MERGE_COLLECT -- requirements
Module: merge_collect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the assembled word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CW, default $clog2(WIDTH+1), giving the width of the length and ones-count fields.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bit_in  input  1  serial data bit from the upstream merge stage's registered output.
REQ-006 bit_valid  input  1  bit_in is valid this cycle; no back-pressure toward upstream.
REQ-007 flush  input  1  emit the partial word now.
REQ-008 word_out  output  WIDTH  assembled word, LSB = first bit received.
REQ-009 word_len  output  CW  number of valid bits in word_out (1..WIDTH).
REQ-010 ones_cnt  output  CW  population count of word_out.
REQ-011 word_valid  output  1  word_out/word_len/ones_cnt are valid.
REQ-012 word_ready  input  1  downstream accepts the word when word_valid && word_ready.
REQ-013 overflow  output  1  sticky flag, a valid bit was dropped.

Function
REQ-014 The block SHALL contain an assembly shift register (asm), a bit counter (cnt, 0..WIDTH), and a single-entry output holding register that drives word_out/word_len/ones_cnt/word_valid.
REQ-015 The FSM SHALL have three states: EMPTY (cnt==0), FILL (0<cnt<WIDTH), STALL (asm complete, holding register occupied).
REQ-016 In EMPTY/FILL, a cycle with bit_valid SHALL write bit_in into asm[cnt] and increment cnt.
REQ-017 When cnt would reach WIDTH and the holding register is free or being accepted this cycle, the word SHALL move to the holding register on the same edge, cnt SHALL clear to 0, and the state SHALL go to EMPTY.
REQ-018 Latency: word_valid SHALL assert on the edge that accepts the WIDTH-th bit, visible the following cycle, with word_len=WIDTH.
REQ-019 When cnt would reach WIDTH while the holding register is occupied and not accepted, asm SHALL keep the full word and the state SHALL go to STALL.
REQ-020 In STALL, bit_valid bits SHALL be dropped and overflow set to 1; flush SHALL be ignored.
REQ-021 In STALL, on a handshake the full asm word SHALL transfer to the holding register on that same edge, with no bubble, and the state SHALL go to EMPTY.
REQ-022 The holding register SHALL keep word_out, word_len and ones_cnt stable while word_valid && !word_ready.
REQ-023 A handshake with no new word SHALL clear word_valid on the next edge.
REQ-024 On flush in FILL, the partial word SHALL transfer as for a full word with word_len=cnt and unfilled upper bits zero; it SHALL enter STALL if the holding register is busy.
REQ-025 Flush with bit_valid in the same cycle SHALL include that bit first, giving word_len=cnt+1.
REQ-026 Flush in EMPTY with no bit_valid SHALL have no effect, since zero-length words are never emitted.
REQ-027 ones_cnt SHALL be computed at transfer time and registered with the word.
REQ-028 CW-bit arithmetic SHALL be sufficient for ones_cnt; cnt SHALL never exceed WIDTH and never wrap.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 While rst_n==0, asynchronously: word_valid=0, word_out=0, word_len=0, ones_cnt=0, overflow=0, cnt=0, asm=0, state=EMPTY.
REQ-031 Reset asserted mid-word or in STALL SHALL discard all partial and held data.
REQ-032 After rst_n deasserts, the first bit_valid in the first clock edge SHALL be accepted.

Verification
REQ-033 WIDTH=8: bits 1,0,1,1,0,0,0,1 on 8 consecutive valid cycles with word_ready=1 -> word_out=8'h8D, word_len=8, ones_cnt=4, word_valid high exactly one cycle, after the 8th bit's edge.
REQ-034 5 valid 1-bits, then flush alone -> word_out=8'h1F, word_len=5, ones_cnt=5; a further flush alone -> no word.
REQ-035 word_ready=0: 16 consecutive valid bits, then 4 more -> first word held stable, second word held in STALL, overflow=1; raise word_ready -> two back-to-back words, no bubble, extra 4 bits lost.
REQ-036 3 valid bits 1,1,1, then bit_valid=1/bit_in=0 together with flush -> word_out=8'h07, word_len=4, ones_cnt=3.
REQ-037 rst_n pulsed low mid-cycle after 5 bits with word_valid=1 -> all outputs 0 immediately; next 8 bits form a fresh word with no residue.
